pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Decodes a single PWM line back into an 8-bit duty-cycle code using the same encoding as the on-chip PWM generators: high_ticks = floor(duty × MAX_COUNT / 256).
- Sits on the receiver/feedback side of the flight controller and measures each pulse's high time and period.
- Recovers duty_cycle with a sequential divider and flags loss of signal.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- PWM_FREQ, 20000, nominal PWM frequency in Hz. Derived localparam MAX_COUNT = CLK_FREQ / PWM_FREQ (5000 at the defaults).
- TIMEOUT_PERIODS, 4, number of nominal periods without any edge before signal_lost is declared. TIMEOUT = TIMEOUT_PERIODS × MAX_COUNT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- pwm_in  input  1  asynchronous PWM line.
- duty_cycle  output  8  last decoded duty code.
- period  output  32  last measured period in clk cycles, rising edge to rising edge.
- duty_valid  output  1  one-cycle strobe when duty_cycle updates.
- signal_lost  output  1  high while no valid PWM is present.
- overrun  output  1  one-cycle strobe when a measurement is dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - duty_cycle=0, period=0, duty_valid=0, overrun=0, signal_lost=1.
  - Synchronizer flops cleared to 0; FSM set to WAIT_RISE; divider idle; all counters 0.
- Input path:
  - pwm_in passes through a 2-flop synchronizer into s; s_d is s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
  - A pin edge is detected on the 3rd rising clk edge after it becomes stable.
- Measurement FSM:
  - WAIT_RISE:
    - On rise: high_cnt=1, per_cnt=1, go to MEAS_HIGH.
    - This first rise does not update period.
  - MEAS_HIGH:
    - Each cycle without fall: high_cnt+1, per_cnt+1.
    - On fall: high_ticks=high_cnt (value not incremented), per_cnt+1, start divider, go to MEAS_LOW.
  - MEAS_LOW:
    - Each cycle: per_cnt+1.
    - On rise: period<=per_cnt, then per_cnt=1, high_cnt=1, go to MEAS_HIGH.
  - Counters saturate at all-ones; they never wrap.
- Timeout:
  - idle_cnt clears on any rise or fall and otherwise increments.
  - When idle_cnt reaches TIMEOUT:
    - signal_lost=1 and the FSM goes to WAIT_RISE.
    - duty_cycle = 8'hFF if s=1, else 8'h00.
    - period is unchanged and duty_valid is not pulsed.
  - signal_lost clears in the same cycle as the next duty_valid.
- Divider:
  - Result q = ceil(high_ticks × 256 / MAX_COUNT) = (high_ticks×256 + MAX_COUNT−1) / MAX_COUNT.
  - This exactly inverts the generator's encoding for every code 0..255, given MAX_COUNT > 256.
  - If high_ticks ≥ MAX_COUNT, q=255 (saturation, checked at start).
  - Implementation: restoring divide, one quotient bit per cycle, MSB first, 8 iteration cycles.
  - Divisor is the constant MAX_COUNT; numerator width is 32+8 bits.
  - Latency: if fall is detected in cycle N, duty_cycle updates and duty_valid=1 in cycle N+9.
  - duty_valid is high for exactly one cycle.
- Overrun:
  - A fall detected while the divider is busy is dropped: high_ticks and the divider are untouched, overrun pulses for 1 cycle, and the FSM still advances normally.
- Simultaneous events:
  - Timeout and an edge in the same cycle: the edge wins and idle_cnt clears.
  - Timeout while the divider is busy: the divider completes and its result overwrites the forced value.
  - The resulting duty_valid clears signal_lost.
- Reset mid-operation: everything is aborted immediately; no duty_valid follows release of reset.

Test Plan:
- Defaults, pwm_in from a PWM generator at duty 128 (2500 high / 5000 period), 3 periods -> duty_valid pulses at each fall+9 with duty_cycle=128; period=5000 from the 2nd rise onward; signal_lost=0 after the first duty_valid.
- Sweep generator duty 1, 100, 255 (high 19, 1953, 4980 cycles) -> duty_cycle = 1, 100, 255 respectively; period=5000.
- Generator duty 0 (line held low) from reset -> no duty_valid; signal_lost stays 1; duty_cycle=0. After 20000 idle cycles, duty_cycle is still 0.
- Established duty 128, then line held high -> 20000 cycles after the last rise: signal_lost=1, duty_cycle=255. Resuming duty 64 -> duty_cycle=64 and signal_lost=0 on the first duty_valid.
- Rise + fall pair 5 cycles apart, then another fall 5 cycles later (period < 9) -> the second fall gives overrun=1 for one cycle; the first result is delivered normally.
- Assert reset during MEAS_HIGH and during divide -> all outputs at reset values within the same cycle, no duty_valid after release; the next full pulse decodes correctly.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM line decoder: measures high time and period of each pulse, recovers the
// 8-bit duty code with a sequential divider and flags loss of signal.
module pwm_capture #(
   parameter int unsigned CLK_FREQ        = 100000000,
   parameter int unsigned PWM_FREQ        = 20000,
   parameter int unsigned TIMEOUT_PERIODS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pwm_in,
   output logic [7:0]  duty_cycle,
   output logic [31:0] period,
   output logic        duty_valid,
   output logic        signal_lost,
   output logic        overrun
);

   localparam int unsigned MAX_COUNT = CLK_FREQ / PWM_FREQ;
   localparam logic [31:0] TIMEOUT   = 32'(TIMEOUT_PERIODS * MAX_COUNT);
   localparam logic [39:0] DIVISOR   = 40'(MAX_COUNT);

   typedef enum logic [1:0] {WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

   state_t      state;
   logic        s_meta, s, s_d;
   logic        rise, fall, timeout;
   logic [31:0] high_cnt, per_cnt, idle_cnt;

   logic        busy, div_sat;
   logic [3:0]  div_cnt;
   logic [39:0] rem, dsor;
   logic [7:0]  quot;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_meta <= 1'b0;
         s      <= 1'b0;
         s_d    <= 1'b0;
      end else begin
         s_meta <= pwm_in;
         s      <= s_meta;
         s_d    <= s;
      end
   end

   assign rise    = s & ~s_d;
   assign fall    = ~s & s_d;
   assign timeout = !(rise || fall) && (idle_cnt == TIMEOUT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= WAIT_RISE;
         high_cnt    <= '0;
         per_cnt     <= '0;
         idle_cnt    <= '0;
         busy        <= 1'b0;
         div_sat     <= 1'b0;
         div_cnt     <= '0;
         rem         <= '0;
         dsor        <= '0;
         quot        <= '0;
         duty_cycle  <= '0;
         period      <= '0;
         duty_valid  <= 1'b0;
         signal_lost <= 1'b1;
         overrun     <= 1'b0;
      end else begin
         duty_valid <= 1'b0;
         overrun    <= 1'b0;

         if (rise || fall)
            idle_cnt <= '0;
         else
            idle_cnt <= sat_inc(idle_cnt);

         case (state)
            WAIT_RISE: begin
               if (rise) begin
                  high_cnt <= 32'd1;
                  per_cnt  <= 32'd1;
                  state    <= MEAS_HIGH;
               end
            end
            MEAS_HIGH: begin
               per_cnt <= sat_inc(per_cnt);
               if (fall) begin
                  state <= MEAS_LOW;
                  if (busy) begin
                     overrun <= 1'b1;
                  end else begin
                     busy    <= 1'b1;
                     div_cnt <= '0;
                     div_sat <= (high_cnt >= MAX_COUNT);
                     rem     <= {high_cnt, 8'h00} + DIVISOR - 40'd1;
                     dsor    <= DIVISOR << 7;
                     quot    <= '0;
                  end
               end else begin
                  high_cnt <= sat_inc(high_cnt);
               end
            end
            MEAS_LOW: begin
               if (rise) begin
                  period   <= per_cnt;
                  per_cnt  <= 32'd1;
                  high_cnt <= 32'd1;
                  state    <= MEAS_HIGH;
               end else begin
                  per_cnt <= sat_inc(per_cnt);
               end
            end
            default: state <= WAIT_RISE;
         endcase

         if (timeout) begin
            state       <= WAIT_RISE;
            signal_lost <= 1'b1;
            duty_cycle  <= s ? 8'hFF : 8'h00;
         end

         // Divider sits after the timeout so a completing result overrides the forced code.
         if (busy) begin
            if (div_cnt == 4'd8) begin
               busy        <= 1'b0;
               duty_cycle  <= div_sat ? 8'hFF : quot;
               duty_valid  <= 1'b1;
               signal_lost <= 1'b0;
            end else begin
               if (rem >= dsor) begin
                  rem  <= rem - dsor;
                  quot <= {quot[6:0], 1'b1};
               end else begin
                  quot <= {quot[6:0], 1'b0};
               end
               dsor    <= dsor >> 1;
               div_cnt <= div_cnt + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: drivers queue expected decodes and overrun
// strobes; a negedge monitor pops and compares whenever the DUT strobes.
`timescale 1ns/1ps
module tb_pwm_capture;

   logic        clk = 1'b0;
   logic        reset;
   logic        pwm_in;
   logic [7:0]  duty_cycle;
   logic [31:0] period;
   logic        duty_valid, signal_lost, overrun;

   pwm_capture #(.CLK_FREQ(100000000), .PWM_FREQ(20000), .TIMEOUT_PERIODS(4)) dut (
      .clk(clk), .reset(reset), .pwm_in(pwm_in), .duty_cycle(duty_cycle), .period(period),
      .duty_valid(duty_valid), .signal_lost(signal_lost), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  duty;
      logic [31:0] per;
      int unsigned cyc;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned ovr_q[$];
   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Pin change at a negedge is seen by the FSM on the 3rd posedge; result 9 cycles later.
   task automatic push_exp(input logic [7:0] d, input logic [31:0] p);
      exp_t e;
      e.duty = d;
      e.per  = p;
      e.cyc  = cyc + 12;
      exp_q.push_back(e);
   endtask

   task automatic pwm_period(input int unsigned high, input int unsigned total,
                             input logic [7:0] d, input logic [31:0] p);
      pwm_in = 1'b1;
      repeat (high) @(negedge clk);
      pwm_in = 1'b0;
      push_exp(d, p);
      repeat (total - high) @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " duty"},    32'(duty_cycle), 32'd0);
      chk({tag, " period"},  period,          32'd0);
      chk({tag, " valid"},   32'(duty_valid), 32'd0);
      chk({tag, " overrun"}, 32'(overrun),    32'd0);
      chk({tag, " lost"},    32'(signal_lost), 32'd1);
   endtask

   // Monitor
   initial begin
      exp_t e;
      int unsigned oc;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && duty_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected duty_valid", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("duty_cycle", 32'(duty_cycle), 32'(e.duty));
               chk("period", period, e.per);
               chk("valid cycle", cyc, e.cyc);
               chk("lost at valid", 32'(signal_lost), 32'd0);
            end
         end
         if (reset === 1'b1 && overrun === 1'b1) begin
            if (ovr_q.size() == 0) begin
               chk("unexpected overrun", 32'd1, 32'd0);
            end else begin
               oc = ovr_q.pop_front();
               chk("overrun cycle", cyc, oc);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned a;
      reset  = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      reset = 1'b1;

      // Line held low from reset: no decode, stays lost with code 0
      repeat (100) @(negedge clk);
      chk("low lost early", 32'(signal_lost), 32'd1);
      repeat (20000) @(negedge clk);
      chk("low lost late", 32'(signal_lost), 32'd1);
      chk("low duty", 32'(duty_cycle), 32'd0);

      // Duty 128, three periods
      pwm_period(2500, 5000, 8'd128, 32'd0);
      pwm_period(2500, 5000, 8'd128, 32'd5000);
      pwm_period(2500, 5000, 8'd128, 32'd5000);
      chk("128 lost", 32'(signal_lost), 32'd0);

      // Line stuck high after a rise
      pwm_in = 1'b1;
      repeat (19990) @(negedge clk);
      chk("high lost early", 32'(signal_lost), 32'd0);
      repeat (20) @(negedge clk);
      chk("high lost", 32'(signal_lost), 32'd1);
      chk("high duty", 32'(duty_cycle), 32'd255);
      chk("high period", period, 32'd5000);

      // Resume at duty 64; period holds its last value
      pwm_in = 1'b0;
      repeat (100) @(negedge clk);
      pwm_period(1250, 5000, 8'd64, 32'd5000);
      chk("64 lost", 32'(signal_lost), 32'd0);

      // Sweep
      pwm_period(19,   5000, 8'd1,   32'd5000);
      pwm_period(1953, 5000, 8'd100, 32'd5000);
      pwm_period(4980, 5000, 8'd255, 32'd5000);

      // Overrun: high 5, low 2, high 3, fall while dividing
      pwm_in = 1'b1;
      repeat (5) @(negedge clk);
      pwm_in = 1'b0;
      a = cyc;
      push_exp(8'd1, 32'd7);
      repeat (2) @(negedge clk);
      pwm_in = 1'b1;
      repeat (3) @(negedge clk);
      pwm_in = 1'b0;
      ovr_q.push_back(cyc + 3);
      chk("overrun gap", cyc - a, 32'd5);
      repeat (40) @(negedge clk);

      // Reset during MEAS_HIGH
      pwm_in = 1'b1;
      repeat (100) @(negedge clk);
      #2 reset = 1'b0;
      #1 chk_reset_vals("rst high");
      repeat (4) @(negedge clk);
      pwm_in = 1'b0;
      #2 reset = 1'b1;
      repeat (20) @(negedge clk);

      // Reset during divide
      pwm_in = 1'b1;
      repeat (1250) @(negedge clk);
      pwm_in = 1'b0;
      repeat (6) @(negedge clk);
      #2 reset = 1'b0;
      #1 chk_reset_vals("rst div");
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      repeat (30) @(negedge clk);

      pwm_period(1953, 5000, 8'd100, 32'd0);
      chk("final lost", 32'(signal_lost), 32'd0);
      repeat (20) @(negedge clk);

      chk("pending decodes", 32'(exp_q.size()), 32'd0);
      chk("pending overruns", 32'(ovr_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
